// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 clock, then
// deframes 11-bit scancode frames into a two-byte key history.
module ps2_scancode_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key,
    output logic        key_valid,
    output logic        frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk;
    logic          bit_event_c;
    logic          sample_c;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;

    // Two-flop synchronizers; reset to the idle-bus level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // filt_cnt counts consecutive samples that disagree with the filtered level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_cnt <= '0;
            filt_clk <= 1'b1;
        end else if (clk_sync[1] == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_sync[1];
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign bit_event_c = filt_clk && !clk_sync[1] && (filt_cnt == FW'(FILTER_LEN - 1));
    assign sample_c    = data_sync[1];

    // Frame deserializer with inactivity timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
            key        <= '0;
            key_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;

            if (bit_event_c || state == IDLE)
                to_cnt <= '0;
            else if (to_cnt != TW'(TIMEOUT_CYCLES))
                to_cnt <= to_cnt + TW'(1);

            if (bit_event_c) begin
                case (state)
                    IDLE: begin
                        if (!sample_c) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift <= {sample_c, shift[7:1]};
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                        else
                            bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: begin
                        parity_bit <= sample_c;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        // Odd parity over data plus parity bit, stop bit high
                        if (sample_c && (^{shift, parity_bit})) begin
                            key       <= {key[7:0], shift};
                            key_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                endcase
            end else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES)) begin
                state   <= IDLE;
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8: consecutive equal ps2_clk samples needed to change the filtered clock level.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100000: clk cycles without a filtered falling edge that abort a partial frame (1 ms at 100 MHz).
REQ-003 Port clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port reset  input  1  one clock; reset is asynchronous and active-high.
REQ-005 Port ps2_clk  input  1  PS/2 keyboard clock pin; asynchronous to clk.
REQ-006 Port ps2_data  input  1  PS/2 keyboard data pin; asynchronous to clk.
REQ-007 Port key  output  16  {previous scancode byte, latest scancode byte}; feeds the player movement logic (break prefix F0 appears in key[15:8]).
REQ-008 Port key_valid  output  1  one-cycle pulse when key updates.
REQ-009 Port frame_err  output  1  one-cycle pulse on parity or stop-bit error.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 The filtered clock SHALL go 0 only after FILTER_LEN consecutive synchronized 0 samples, go 1 only after FILTER_LEN consecutive 1 samples, and otherwise hold.
REQ-012 A bit event SHALL be the single clk cycle in which the filtered clock changes 1->0; synchronized ps2_data is sampled in that cycle.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: on a bit event with data 0 (start bit) -> DATA with bit count 0; on a bit event with data 1 -> stay in IDLE, no output.
REQ-015 DATA: each bit event shifts the sample in LSB-first; after the 8th bit -> PARITY.
REQ-016 PARITY: on a bit event, store the sample; -> STOP.
REQ-017 STOP: on a bit event -> IDLE; frame is good iff the stop sample is 1 and data byte plus parity bit has odd weight.
REQ-018 Good frame: in the cycle after the stop-bit event, key <= {key[7:0], byte} and key_valid = 1 for exactly that cycle.
REQ-019 Bad frame (parity or stop error): key unchanged, key_valid stays 0, frame_err = 1 for exactly the cycle after the stop-bit event.
REQ-020 Timeout counter SHALL clear on every bit event and while in IDLE, and increment otherwise; when it reaches TIMEOUT_CYCLES in DATA/PARITY/STOP, the FSM SHALL return to IDLE, discard the partial byte, and pulse neither key_valid nor frame_err.
REQ-021 Timeout and a bit event in the same cycle: the bit event wins and the counter clears.
REQ-022 key_valid and frame_err SHALL never assert in the same cycle; back-to-back frames SHALL each produce their own pulse.
REQ-023 The block SHALL have no transmit path: ps2_clk and ps2_data are never driven.
REQ-024 The counter width SHALL hold TIMEOUT_CYCLES without wrap; the bit counter SHALL not exceed 7.

Reset
REQ-025 While reset = 1: key = 16'h0000, key_valid = 0, frame_err = 0, FSM = IDLE, bit count = 0, timeout counter = 0, synchronizer and filter state = all ones (idle bus), filtered clock = 1.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first bit event after release is treated in IDLE.
REQ-027 The first bit event after reset release requires FILTER_LEN low samples from the all-ones state, so an initially low ps2_clk does not produce a spurious event before that.

Verification
REQ-028 After reset, send frame 0x1C (parity 0, stop 1) -> key = 16'h001C, a single key_valid pulse, frame_err never asserts.
REQ-029 Then send frames 0xF0, 0x1C -> key = 16'hF01C after the second frame, key = 16'h1CF0 in between, two key_valid pulses.
REQ-030 Send 0x23 with the parity bit inverted -> frame_err pulses once, key unchanged, no key_valid.
REQ-031 Inject a ps2_clk low glitch lasting FILTER_LEN-1 clk cycles in IDLE with data 0 -> no state change, no pulses; a FILTER_LEN-cycle low is accepted as a start bit.
REQ-032 Send start + 3 data bits, stall for TIMEOUT_CYCLES+10 cycles, then a full 0x1D frame -> no pulses during the stall, then key[7:0] = 8'h1D with one key_valid.
REQ-033 Assert reset for 3 cycles during the 5th data bit of a frame, then send 0x1B -> key = 16'h001B, exactly one key_valid, no frame_err.
